// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the register file write port.
// Each requester owns a one-entry buffer; the oldest full buffer drains first, ties go round-robin.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [ADDR_W-1:0]        req0_reg,
    input  logic [DATA_W-1:0]        req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [ADDR_W-1:0]        req1_reg,
    input  logic [DATA_W-1:0]        req1_data,
    output logic [ADDR_W-1:0]        Write_register,
    output logic [DATA_W-1:0]        Write_data,
    output logic                     signal_RegWrite,
    output logic [1:0]               grant,
    output logic [(1<<ADDR_W)-1:0]   pending_mask
);

    localparam int NREG = 1 << ADDR_W;

    logic [1:0]        r_vld_p0;
    logic [1:0]        r_old_p0;
    logic              r_rr_ptr;
    logic [ADDR_W-1:0] r_reg_p0  [2];
    logic [DATA_W-1:0] r_data_p0 [2];

    logic [1:0]        w_valid;
    logic [1:0]        w_ready;
    logic [1:0]        w_load;
    logic [1:0]        w_grant;
    logic [1:0]        w_vld_next;
    logic              w_tie;
    logic              w_sel;
    logic              w_any;
    logic [ADDR_W-1:0] w_in_reg  [2];
    logic [DATA_W-1:0] w_in_data [2];
    logic [NREG-1:0]   w_mask;

    assign w_valid      = {req1_valid, req0_valid};
    assign w_in_reg[0]  = req0_reg;
    assign w_in_reg[1]  = req1_reg;
    assign w_in_data[0] = req0_data;
    assign w_in_data[1] = req1_data;

    // Arbitration looks only at buffer state, so no input reaches an output combinationally.
    always_comb begin
        w_grant = 2'b00;
        w_tie   = 1'b0;
        case (r_vld_p0)
            2'b01: w_grant = 2'b01;
            2'b10: w_grant = 2'b10;
            2'b11: begin
                if (r_old_p0 == 2'b01) begin
                    w_grant = 2'b01;
                end else if (r_old_p0 == 2'b10) begin
                    w_grant = 2'b10;
                end else begin
                    w_tie   = 1'b1;
                    w_grant = r_rr_ptr ? 2'b10 : 2'b01;
                end
            end
            default: w_grant = 2'b00;
        endcase
    end

    assign w_ready    = ~r_vld_p0 | w_grant;
    assign w_load     = w_valid & w_ready;
    assign w_vld_next = (r_vld_p0 & ~w_grant) | w_load;
    assign w_any      = |w_grant;
    assign w_sel      = w_grant[1];

    // Stage p0: buffer occupancy, age and tie pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p0 <= 2'b00;
            r_old_p0 <= 2'b00;
            r_rr_ptr <= 1'b0;
        end else begin
            r_vld_p0 <= w_vld_next;
            for (int i = 0; i < 2; i++) begin
                // An entry becomes "old" once the other buffer is loaded behind it.
                if (w_load[i] || !w_vld_next[i]) begin
                    r_old_p0[i] <= 1'b0;
                end else if (w_load[i ^ 1]) begin
                    r_old_p0[i] <= 1'b1;
                end
            end
            if (w_tie) begin
                r_rr_ptr <= ~r_rr_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_load[i]) begin
                r_reg_p0[i]  <= w_in_reg[i];
                r_data_p0[i] <= w_in_data[i];
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (r_vld_p0[i] && (r_reg_p0[i] != '0)) begin
                w_mask[r_reg_p0[i]] = 1'b1;
            end
        end
    end

    assign req0_ready      = w_ready[0];
    assign req1_ready      = w_ready[1];
    assign grant           = w_grant;
    assign Write_register  = w_any ? r_reg_p0[w_sel]  : '0;
    assign Write_data      = w_any ? r_data_p0[w_sel] : '0;
    assign signal_RegWrite = w_any && (r_reg_p0[w_sel] != '0);
    assign pending_mask    = w_mask;

endmodule
